sobel_ahb_slave: RTL

SOBEL_AHB_SLAVE -- requirements
Module: sobel_ahb_slave

---
 rtl/sobel_ahb_slave.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sobel_ahb_slave.sv
// AHB-Lite slave that hands a pixel window to a Sobel engine and queues its results.
// Optional macro SOBEL_AHB_ERR_EN: illegal-direction accesses get a two-cycle ERROR response.
module sobel_ahb_slave #(
  parameter int PIX_W     = 4,
  parameter int WIN       = 4,
  parameter int RES_DEPTH = 4,
  localparam int DATA_W   = WIN*WIN*PIX_W + 4,
  localparam int PIX_BITS = WIN*WIN*PIX_W
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic                HREADY,
  input  logic                HWRITE,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HSIZE,
  input  logic [DATA_W-1:0]   HWDATA,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [PIX_BITS-1:0] pixels,
  output logic [3:0]          brightness_value,
  output logic                load_enable,
  input  logic                buf_ready,
  input  logic                res_valid,
  input  logic [PIX_W-1:0]    res_data,
  output logic                res_ready
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [1:0] A_WIN = 2'd0, A_RES = 2'd1, A_STAT = 2'd2, A_CTRL = 2'd3;

  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, ERR1, ERR2} state_t;

  state_t           state;
  logic             vld_p1, wr_p1;
  logic [1:0]       addr_p1;
  logic [PIX_W-1:0] mem [RES_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop, load, active_a, err_a;
  logic             unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

  assign full      = (count == (AW+1)'(RES_DEPTH));
  assign empty     = (count == '0);
  assign res_ready = !full;
  assign push      = res_valid && !full;
  assign active_a  = HSEL && HTRANS[1];

`ifdef SOBEL_AHB_ERR_EN
  function automatic logic illegal(input logic wr, input logic [1:0] a);
    return wr ? (a == A_RES || a == A_STAT) : (a == A_WIN);
  endfunction
  // Illegal accesses are caught in the address phase so ERR1 covers the first data-phase cycle.
  assign err_a = HREADY && active_a && illegal(HWRITE, HADDR[3:2]);
`else
  assign err_a = 1'b0;
`endif

  // Data phase: response depends on live buf_ready / FIFO level, so it is combinational.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (vld_p1 && wr_p1 && addr_p1 == A_WIN) begin
          HREADYOUT = buf_ready;
          load      = buf_ready;
        end else if (vld_p1 && !wr_p1) begin
          case (addr_p1)
            A_RES: begin
              HREADYOUT = !empty;
              pop       = !empty;
              if (!empty) HRDATA = DATA_W'(mem[rptr]);
            end
            A_STAT:  HRDATA = DATA_W'({count, full, empty});
            A_CTRL:  HRDATA = DATA_W'(brightness_value);
            default: HRDATA = '0;
          endcase
        end
      end
      WR_WAIT: begin
        HREADYOUT = buf_ready;
        load      = buf_ready;
      end
      RD_WAIT: begin
        HREADYOUT = !empty;
        pop       = !empty;
        if (!empty) HRDATA = DATA_W'(mem[rptr]);
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2:    HRESP = 1'b1;
      default: HREADYOUT = 1'b1;
    endcase
  end

  // Address phase capture, FSM, output registers and FIFO pointers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state            <= IDLE;
      vld_p1           <= 1'b0;
      wr_p1            <= 1'b0;
      addr_p1          <= '0;
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      pixels           <= '0;
      brightness_value <= 4'b0010;
      load_enable      <= 1'b0;
    end else begin
      load_enable <= load;
      if (HREADY) begin
        vld_p1  <= active_a && !err_a;
        wr_p1   <= HWRITE;
        addr_p1 <= HADDR[3:2];
      end
      case (state)
        IDLE: begin
          if (vld_p1 && wr_p1 && addr_p1 == A_WIN && !buf_ready) state <= WR_WAIT;
          else if (vld_p1 && !wr_p1 && addr_p1 == A_RES && empty) state <= RD_WAIT;
          else if (err_a) state <= ERR1;
        end
        WR_WAIT: if (buf_ready) state <= err_a ? ERR1 : IDLE;
        RD_WAIT: if (!empty) state <= err_a ? ERR1 : IDLE;
        ERR1:    state <= ERR2;
        ERR2:    state <= err_a ? ERR1 : IDLE;
        default: state <= IDLE;
      endcase
      if (load) begin
        pixels           <= HWDATA[DATA_W-1:4];
        brightness_value <= HWDATA[3:0];
      end else if (state == IDLE && vld_p1 && wr_p1 && addr_p1 == A_CTRL) begin
        brightness_value <= HWDATA[3:0];
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wptr] <= res_data;
  end

endmodule
